rv32i_issue_scoreboard: RTL and testbench
=========================================

Name: rv32i_issue_scoreboard

Overview:
- Sits between the RV32I decode stage and the execute pipes; holds each decoded instruction until it is hazard-free, then issues it.
- Tracks in-flight register writes with a per-register pending counter, so read-after-write and multiple outstanding writes to the same rd are handled.
- Serializes SYSTEM and FENCE instructions by draining all outstanding writes first.
- Uses a single registered output slot with a valid/ready handshake on both sides.

Parameters:
- COUNT_WIDTH, 2: width of each per-register pending-write counter (max outstanding writes per rd = 2^COUNT_WIDTH-1).

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- dec_valid  in  1  decoded instruction valid
- dec_ready  out  1  instruction accepted this cycle
- dec_inst  in  32  raw instruction word
- iss_valid  out  1  output slot holds an issued instruction
- iss_ready  in  1  execute accepts the slot
- iss_inst  out  32  issued instruction word
- iss_illegal  out  1  issued opcode is not a defined RV32I opcode
- wb_valid  in  1  a register write retired
- wb_rd  in  5  destination of the retired write
- pending  out  32  bit i = counter[i] != 0; bit 0 always 0
- err_underflow  out  1  sticky: writeback arrived for a zero counter

Behaviour:
- Reset values: iss_valid=0, iss_inst=0, iss_illegal=0, all counters 0, pending=0, err_underflow=0, FSM=RUN.
- Field extraction: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20].
- Register usage per opcode:
  - OP, STORE, BRANCH: rs1 and rs2.
  - IMM, LOAD, JALR: rs1.
  - OP, IMM, LOAD, LUI, AUIPC, JAL, JALR: write rd.
  - SYSTEM with funct3 1/2/3: rs1 and rd. SYSTEM with funct3 5/6/7: rd only. SYSTEM with funct3 0 (ECALL/EBREAK) and FENCE: no registers.
  - Any other opcode: no registers, iss_illegal=1 on issue.
  - x0 is never a hazard and is never counted.
- Hazard condition: a used rs with counter != 0, or a written rd whose counter is at its maximum.
  - The check uses registered counters only; there is no same-cycle writeback bypass, so a clearing writeback lets the instruction issue one cycle later.
- Slot free: slot_free = !iss_valid || iss_ready.
- FSM:
  - RUN, non-serializing instruction: dec_ready = dec_valid && slot_free && !hazard.
  - RUN, SYSTEM or FENCE at dec_inst with dec_valid: dec_ready=0 and FSM moves to DRAIN.
  - DRAIN: dec_ready = slot_free && !iss_valid && all counters zero && !hazard. On the accepting cycle FSM returns to RUN.
  - Decode must hold dec_inst stable while dec_valid=1 and dec_ready=0. If dec_valid drops while in DRAIN, FSM returns to RUN.
- Issue (dec_valid && dec_ready): on the next edge iss_valid=1 and iss_inst/iss_illegal are loaded; counter[rd]+1 if rd is written and rd != 0. Latency is 1 cycle from accept to iss_valid.
- Slot hold: iss_valid && !iss_ready holds the slot contents stable. iss_valid && iss_ready with no new accept clears iss_valid.
- Writeback (wb_valid, wb_rd != 0): counter[wb_rd]-1.
  - On a zero counter: the counter holds at 0 and err_underflow is set until reset.
  - wb_rd=0 is ignored.
- Simultaneous increment and decrement on the same register leaves the counter unchanged.
- Reset mid-operation clears all state immediately (asynchronous). In-flight writebacks after reset raise err_underflow.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) -> accepted cycle 0; iss_valid at cycle 1; pending=0x00000002. Then wb_rd=1 -> pending=0.
- 0x00500093 then add x2,x1,x1 (0x00108133), no writeback -> add stalls (dec_ready=0). Pulse wb_rd=1 at cycle 5 -> add accepted cycle 6; pending=0x00000004.
- COUNT_WIDTH=2, three back-to-back addi x1 with no writeback -> counter[1]=3; fourth stalls until one wb_rd=1, then issues.
- Counter[3]=1 with issue of lw x3,0(x0) (0x00002183) and wb_rd=3 in the same cycle -> counter[3] stays 1.
- Counter[1]=1, then csrrs x5,cycle,x0 (0xC00022F3) -> FSM=DRAIN, dec_ready=0. After wb_rd=1 and an empty slot -> accepted; pending=0x00000020.
- With iss_ready=0, issue addi then present 0x00108133 -> slot holds 0x00500093 stable; dec_ready=0. wb_rd=0 with empty counters -> no change. wb_rd=7 with counter 0 -> err_underflow=1, cleared only by rst.

Source files
------------

// File: rtl/rv32i_issue_scoreboard.sv
// rv32i_issue_scoreboard
// Holds one decoded RV32I instruction until its source registers have no
// outstanding writes and its destination counter has headroom, then moves it
// into a single registered issue slot. SYSTEM and FENCE wait until every
// outstanding write has retired and the issue slot is empty.

module rv32i_issue_scoreboard #(
  parameter int COUNT_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [31:0] dec_inst,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [31:0] iss_inst,
  output logic        iss_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] pending,
  output logic        err_underflow
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic        iss_valid_reg;
  logic [31:0] iss_inst_reg;
  logic        iss_illegal_reg;
  logic        err_reg;

  // Per-register status derived from the counters (bit 0 tied low: x0)
  logic [31:0] cnt_nonzero;
  logic [31:0] cnt_full;
  logic [31:0] underflow_hit;

  // Decoded fields and register usage
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       use_rs1, use_rs2, writes_rd, is_illegal, is_serial;
  logic       hazard, all_zero, slot_free, accept;

  assign opcode = dec_inst[6:0];
  assign rd     = dec_inst[11:7];
  assign funct3 = dec_inst[14:12];
  assign rs1    = dec_inst[19:15];
  assign rs2    = dec_inst[24:20];

  // Classify the instruction at the decode port by opcode
  always_comb begin
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    writes_rd  = 1'b0;
    is_illegal = 1'b0;
    is_serial  = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_IMM, OPC_LOAD, OPC_JALR: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        writes_rd = 1'b1;
      end
      OPC_FENCE: begin
        is_serial = 1'b1;
      end
      OPC_SYSTEM: begin
        is_serial = 1'b1;
        case (funct3)
          3'd1, 3'd2, 3'd3: begin
            use_rs1   = 1'b1;
            writes_rd = 1'b1;
          end
          3'd5, 3'd6, 3'd7: writes_rd = 1'b1;
          default: ;
        endcase
      end
      default: is_illegal = 1'b1;
    endcase
  end

  // x0 reports neither nonzero nor full, so it never creates a hazard
  assign hazard    = (use_rs1 && cnt_nonzero[rs1]) ||
                     (use_rs2 && cnt_nonzero[rs2]) ||
                     (writes_rd && cnt_full[rd]);
  assign all_zero  = ~|cnt_nonzero;
  assign slot_free = !iss_valid_reg || iss_ready;
  assign accept    = dec_valid && dec_ready;

  // Issue control: RUN accepts ordinary work, DRAIN waits for a quiet machine
  always_comb begin
    state_next = state_reg;
    dec_ready  = 1'b0;
    case (state_reg)
      RUN: begin
        if (dec_valid && is_serial) begin
          state_next = DRAIN;
        end else begin
          dec_ready = dec_valid && slot_free && !hazard;
        end
      end
      DRAIN: begin
        if (!dec_valid) begin
          state_next = RUN;
        end else begin
          dec_ready = slot_free && !iss_valid_reg && all_zero && !hazard;
          if (dec_ready) state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // Issue slot: load on accept, drop when consumed, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_reg   <= 1'b0;
      iss_inst_reg    <= '0;
      iss_illegal_reg <= 1'b0;
    end else if (accept) begin
      iss_valid_reg   <= 1'b1;
      iss_inst_reg    <= dec_inst;
      iss_illegal_reg <= is_illegal;
    end else if (iss_ready) begin
      iss_valid_reg   <= 1'b0;
    end
  end

  assign cnt_nonzero[0]   = 1'b0;
  assign cnt_full[0]      = 1'b0;
  assign underflow_hit[0] = 1'b0;

  // One pending-write counter per architectural register x1..x31
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
      logic [COUNT_WIDTH-1:0] cnt_reg;
      logic                   inc, dec;

      assign inc = accept && writes_rd && (rd == 5'(gi));
      assign dec = wb_valid && (wb_rd == 5'(gi));

      assign cnt_nonzero[gi]   = (cnt_reg != '0);
      assign cnt_full[gi]      = (cnt_reg == '1);
      assign underflow_hit[gi] = dec && !inc && (cnt_reg == '0);

      // Count issued writes up and retired writes down; saturate at zero
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (inc && !dec) begin
          cnt_reg <= cnt_reg + COUNT_WIDTH'(1);
        end else if (dec && !inc && (cnt_reg != '0)) begin
          cnt_reg <= cnt_reg - COUNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  // Sticky flag for a writeback that had no matching issued write
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_reg <= 1'b0;
    else if (|underflow_hit) err_reg <= 1'b1;
  end

  assign iss_valid     = iss_valid_reg;
  assign iss_inst      = iss_inst_reg;
  assign iss_illegal   = iss_illegal_reg;
  assign pending       = cnt_nonzero;
  assign err_underflow = err_reg;

endmodule

// File: tb/tb_rv32i_issue_scoreboard.sv
// tb_rv32i_issue_scoreboard
// Directed sequence; every accepted instruction is queued and compared
// against the issue slot when execute consumes it.

module tb_rv32i_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_inst;
  logic        iss_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] pending;
  logic        err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];

  localparam logic [31:0] ADDI_X1  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD_X2   = 32'h00108133; // add x2,x1,x1
  localparam logic [31:0] LW_X3    = 32'h00002183; // lw x3,0(x0)
  localparam logic [31:0] CSRRS_X5 = 32'hC00022F3; // csrrs x5,cycle,x0
  localparam logic [31:0] FENCE_I  = 32'h0000000F; // fence
  localparam logic [31:0] LUI_X4   = 32'h00005237; // lui x4,5
  localparam logic [31:0] BAD_OPC  = 32'h0000007F; // undefined opcode

  rv32i_issue_scoreboard #(.COUNT_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_inst      (iss_inst),
    .iss_illegal   (iss_illegal),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .pending       (pending),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic opc_legal(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    case (op)
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
      7'h0F, 7'h73: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input int cycles);
    wb_valid = 1'b1;
    wb_rd    = r;
    repeat (cycles) tick();
    wb_valid = 1'b0;
    wb_rd    = '0;
  endtask

  // Scoreboard: compare the slot when consumed, then queue any new accept
  always @(negedge clk) begin
    if (!rst) begin
      if (iss_valid && iss_ready) begin
        chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          logic [31:0] e;
          e = sb_q.pop_front();
          chk("sb_inst", iss_inst, e);
          chk("sb_illegal", 32'(iss_illegal), 32'(!opc_legal(e)));
          $display("issue  inst=%h illegal=%0b", iss_inst, iss_illegal);
        end
      end
      if (dec_valid && dec_ready) begin
        sb_q.push_back(dec_inst);
        $display("accept inst=%h", dec_inst);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    dec_valid = 1'b0;
    dec_inst  = '0;
    iss_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_iss_inst", iss_inst, 32'd0);
    chk("rst_iss_illegal", 32'(iss_illegal), 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    chk("rst_dec_ready", 32'(dec_ready), 32'd0);

    // addi x1: one-cycle latency, x1 pending until its writeback
    dec_valid = 1'b1; dec_inst = ADDI_X1;
    settle();
    chk("t1_ready", 32'(dec_ready), 32'd1);
    tick();
    dec_valid = 1'b0;
    chk("t1_iss_valid", 32'(iss_valid), 32'd1);
    chk("t1_iss_inst", iss_inst, ADDI_X1);
    chk("t1_pending", pending, 32'h00000002);
    wb(5'd1, 1);
    chk("t1_pending_clr", pending, 32'd0);
    chk("t1_slot_empty", 32'(iss_valid), 32'd0);

    // RAW: add x2 stalls on x1, issues the cycle after the writeback
    dec_valid = 1'b1; dec_inst = ADDI_X1;
    tick();
    dec_inst = ADD_X2;
    settle();
    chk("t2_stall_a", 32'(dec_ready), 32'd0);
    tick();
    chk("t2_stall_b", 32'(dec_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd1;
    settle();
    chk("t2_no_bypass", 32'(dec_ready), 32'd0);
    tick();
    wb_valid = 1'b0; wb_rd = '0;
    settle();
    chk("t2_ready_after_wb", 32'(dec_ready), 32'd1);
    tick();
    dec_valid = 1'b0;
    chk("t2_pending", pending, 32'h00000004);
    wb(5'd2, 1);
    chk("t2_pending_clr", pending, 32'd0);

    // Counter saturation: three writes to x1 outstanding, fourth waits
    dec_valid = 1'b1; dec_inst = ADDI_X1;
    repeat (3) tick();
    settle();
    chk("t3_full_stall", 32'(dec_ready), 32'd0);
    chk("t3_pending", pending, 32'h00000002);
    wb_valid = 1'b1; wb_rd = 5'd1;
    tick();
    wb_valid = 1'b0; wb_rd = '0;
    settle();
    chk("t3_ready_after_wb", 32'(dec_ready), 32'd1);
    tick();
    dec_valid = 1'b0;
    wb(5'd1, 2);
    chk("t3_still_pending", pending, 32'h00000002);
    wb(5'd1, 1);
    chk("t3_drained", pending, 32'd0);
    chk("t3_no_err", 32'(err_underflow), 32'd0);

    // Same-cycle increment and decrement on x3 leaves its counter at 1
    dec_valid = 1'b1; dec_inst = LW_X3;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3;
    settle();
    chk("t4_ready", 32'(dec_ready), 32'd1);
    tick();
    dec_valid = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    chk("t4_pending", pending, 32'h00000008);
    wb(5'd3, 1);
    chk("t4_pending_clr", pending, 32'd0);
    chk("t4_no_err", 32'(err_underflow), 32'd0);

    // CSR read waits in DRAIN for x1 to retire
    dec_valid = 1'b1; dec_inst = ADDI_X1;
    tick();
    dec_inst = CSRRS_X5;
    settle();
    chk("t5_csr_stall", 32'(dec_ready), 32'd0);
    tick();
    chk("t5_drain_stall", 32'(dec_ready), 32'd0);
    wb(5'd1, 1);
    settle();
    chk("t5_drain_ready", 32'(dec_ready), 32'd1);
    tick();
    dec_valid = 1'b0;
    chk("t5_iss_inst", iss_inst, CSRRS_X5);
    chk("t5_pending", pending, 32'h00000020);
    wb(5'd5, 1);
    chk("t5_pending_clr", pending, 32'd0);

    // Withdrawn FENCE returns the FSM to RUN
    dec_valid = 1'b1; dec_inst = ADDI_X1;
    tick();
    dec_inst = FENCE_I;
    tick();
    dec_valid = 1'b0;
    tick();
    dec_valid = 1'b1; dec_inst = LUI_X4;
    settle();
    chk("t6_run_ready", 32'(dec_ready), 32'd1);
    tick();
    dec_valid = 1'b0;
    chk("t6_pending", pending, 32'h00000012);
    wb(5'd1, 1);
    wb(5'd4, 1);
    chk("t6_pending_clr", pending, 32'd0);

    // Undefined opcode issues with the illegal flag
    dec_valid = 1'b1; dec_inst = BAD_OPC;
    tick();
    dec_valid = 1'b0;
    chk("t7_illegal", 32'(iss_illegal), 32'd1);
    chk("t7_pending", pending, 32'd0);
    tick();

    // Backpressure: slot holds, x0 writeback ignored
    iss_ready = 1'b0;
    dec_valid = 1'b1; dec_inst = ADDI_X1;
    settle();
    chk("t8_ready_empty_slot", 32'(dec_ready), 32'd1);
    tick();
    dec_inst = ADD_X2;
    settle();
    chk("t8_stall", 32'(dec_ready), 32'd0);
    wb(5'd0, 1);
    chk("t8_hold_inst", iss_inst, ADDI_X1);
    chk("t8_hold_valid", 32'(iss_valid), 32'd1);
    chk("t8_x0_wb_pending", pending, 32'h00000002);
    chk("t8_x0_wb_err", 32'(err_underflow), 32'd0);
    iss_ready = 1'b1;
    tick();
    chk("t8_slot_drained", 32'(iss_valid), 32'd0);
    wb(5'd1, 1);
    settle();
    chk("t8_ready_after_wb", 32'(dec_ready), 32'd1);
    tick();
    dec_valid = 1'b0;
    chk("t8_pending", pending, 32'h00000004);
    wb(5'd2, 1);

    // Underflow on x7 is sticky until reset
    wb(5'd7, 1);
    chk("t9_err_set", 32'(err_underflow), 32'd1);
    chk("t9_pending", pending, 32'd0);
    tick();
    chk("t9_err_sticky", 32'(err_underflow), 32'd1);

    // Asynchronous reset clears state without a clock edge
    dec_valid = 1'b1; dec_inst = ADDI_X1;
    tick();
    dec_valid = 1'b0;
    chk("t10_pre_valid", 32'(iss_valid), 32'd1);
    rst = 1'b1;
    settle();
    chk("t10_async_valid", 32'(iss_valid), 32'd0);
    chk("t10_async_pending", pending, 32'd0);
    chk("t10_async_err", 32'(err_underflow), 32'd0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();

    chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
